// File: rtl/fetch_pkg.sv
// Shared constants, decoder opcodes and queue-entry type for the fetch stage.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package fetch_pkg;

    localparam int XLEN_DEF = 32;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes shared with the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // One slot of the fetch queue: allocated with its pc, filled later by memory
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] data;
        logic                filled;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: slots allocated at request time, filled in order by responses, popped by decode.
// Latency: a fill is visible at the head on the cycle after the filling edge.
// Backpressure: caller gates allocEn on allocCount < DEPTH; popEn frees a slot for the following cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                allocEn,
    input  logic [XLEN_DEF-1:0] allocPc,
    input  logic                fillEn,
    input  logic [XLEN_DEF-1:0] fillData,
    input  logic                popEn,
    output fetchEntry_t         headEntry,
    output logic [CW-1:0]       allocCount,
    output logic [CW-1:0]       unfilledCount
);

    fetchEntry_t   entries [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [PW-1:0] fillPtr;
    logic [CW-1:0] allocCnt;
    logic [CW-1:0] unfilledCnt;

    // Ring storage: allocate at tail, fill at the oldest unfilled slot, free at head; flush empties all.
    // The three indices never collide: tail is free, fill is allocated-unfilled, head is filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            headPtr     <= '0;
            tailPtr     <= '0;
            fillPtr     <= '0;
            allocCnt    <= '0;
            unfilledCnt <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            headPtr     <= '0;
            tailPtr     <= '0;
            fillPtr     <= '0;
            allocCnt    <= '0;
            unfilledCnt <= '0;
        end else begin
            if (allocEn) begin
                entries[tailPtr].pc     <= allocPc;
                entries[tailPtr].filled <= 1'b0;
                tailPtr                 <= tailPtr + PW'(1);
            end
            if (fillEn) begin
                entries[fillPtr].data   <= fillData;
                entries[fillPtr].filled <= 1'b1;
                fillPtr                 <= fillPtr + PW'(1);
            end
            if (popEn) begin
                entries[headPtr].filled <= 1'b0;
                headPtr                 <= headPtr + PW'(1);
            end
            allocCnt    <= allocCnt + CW'(allocEn) - CW'(popEn);
            unfilledCnt <= unfilledCnt + CW'(allocEn) - CW'(fillEn);
        end
    end

    assign headEntry     = entries[headPtr];
    assign allocCount    = allocCnt;
    assign unfilledCount = unfilledCnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, gated in-order memory requests, response queue, redirect with stale-response drop.
// Latency: with 1-cycle memory the first instruction is valid 2 cycles after reset release.
// Backpressure: requests stop when DEPTH slots are allocated; instr_ready low holds the head instruction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      instr_op,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4
);

    localparam int CW = $clog2(DEPTH + 1);
    // Old-stream requests can still be in flight while a new stream fills the queue,
    // so a second redirect may leave up to 2*DEPTH responses to discard.
    localparam int DW = $clog2(2 * DEPTH + 1);

    logic [XLEN-1:0] pcReg;
    logic [DW-1:0]   dropCnt;
    fetchEntry_t     headEntry;
    logic [CW-1:0]   allocCount;
    logic [CW-1:0]   unfilledCount;
    logic            reqFire;
    logic            rspKeep;
    logic            popFire;

    assign imem_req_valid = reset & ~redirect & (allocCount < CW'(DEPTH));
    assign imem_req_addr  = pcReg;
    assign reqFire        = imem_req_valid & imem_req_ready;
    assign rspKeep        = imem_rsp_valid & ~redirect & (dropCnt == '0);

    assign instr_valid    = (allocCount != '0) & headEntry.filled;
    assign popFire        = instr_valid & instr_ready;
    assign instr          = instr_valid ? headEntry.data[31:0] : NOP_INSTR;
    assign instr_op       = instr[6:0];
    assign instr_pc       = XLEN'(headEntry.pc);
    assign instr_pcplus4  = instr_pc + XLEN'(4);

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (reset),
        .flush        (redirect),
        .allocEn      (reqFire),
        .allocPc      (XLEN_DEF'(pcReg)),
        .fillEn       (rspKeep),
        .fillData     (XLEN_DEF'(imem_rsp_data)),
        .popEn        (popFire),
        .headEntry    (headEntry),
        .allocCount   (allocCount),
        .unfilledCount(unfilledCount)
    );

    // Program counter: redirect wins over advancing on an accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcReg <= RESET_PC;
        end else if (redirect) begin
            pcReg <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (reqFire) begin
            pcReg <= pcReg + XLEN'(4);
        end
    end

    // Stale-response counter: on redirect every outstanding old request becomes a drop,
    // and any response arriving in that cycle retires one of them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropCnt <= '0;
        end else if (redirect) begin
            dropCnt <= dropCnt + DW'(unfilledCount) - DW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (dropCnt != '0)) begin
            dropCnt <= dropCnt - DW'(1);
        end
    end

    // A response must always have a stale slot or an unfilled entry to land in.
    rspProtocolChk: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> ((dropCnt != '0) || (unfilledCount != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  instr_op;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_op      (instr_op),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } expItem_t;

    memReq_t     pendQ[$];
    expItem_t    expQ[$];
    int          testCnt = 0;
    int          failCnt = 0;
    int          cyc = 0;
    int          lat = 1;
    int          popCnt = 0;
    int          fireCnt = 0;
    int          firstValidCyc = -1;
    logic        lastReqValid;
    logic [31:0] nextAddr = RESET_PC;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[26:2], OP_RTYPE};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe handshakes mid-cycle, then advance the memory and scoreboard.
    task automatic step();
        logic        fire;
        logic        pop;
        logic        redir;
        logic        rspSeen;
        logic [31:0] addr;
        logic [31:0] rPc;
        expItem_t    e;
        memReq_t     m;
        @(negedge clk);
        fire         = reset && imem_req_valid && imem_req_ready;
        addr         = imem_req_addr;
        pop          = reset && instr_valid && instr_ready;
        redir        = redirect;
        rPc          = redirect_pc;
        rspSeen      = imem_rsp_valid;
        lastReqValid = imem_req_valid;
        if (instr_valid && firstValidCyc < 0) firstValidCyc = cyc;
        if (pop) begin
            popCnt++;
            check("sb_nonempty_at_pop", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr_pcplus4", instr_pcplus4, e.pc + 32'd4);
                check("instr", instr, e.data);
                check("instr_op", {25'd0, instr_op}, {25'd0, e.data[6:0]});
            end
        end
        if (fire) begin
            fireCnt++;
            check("req_addr", addr, nextAddr);
            e.pc   = nextAddr;
            e.data = memWord(nextAddr);
            expQ.push_back(e);
            nextAddr = nextAddr + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rspSeen && pendQ.size() > 0) void'(pendQ.pop_front());
        if (redir) begin
            expQ.delete();
            nextAddr = {rPc[31:2], 2'b00};
        end
        if (fire) begin
            m.addr = addr;
            m.due  = cyc + lat - 1;
            pendQ.push_back(m);
        end
        if (reset && pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pendQ[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic drain(input string tag);
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        for (int i = 0; i < 40 && (expQ.size() != 0 || pendQ.size() != 0); i++) step();
        check(tag, 32'(expQ.size() + pendQ.size()), 32'd0);
    endtask

    task automatic runPops(input int n, input string tag);
        popCnt = 0;
        for (int i = 0; i < 60 && popCnt < n; i++) step();
        check(tag, 32'(popCnt), 32'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_instr_op", {25'd0, instr_op}, {25'd0, OP_ITYPE});
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_pcplus4", instr_pcplus4, 32'h4);

        // Decode stalled from release: only DEPTH requests go out, head holds pc 0
        reset          = 1'b1;
        cyc            = 0;
        lat            = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        fireCnt        = 0;
        repeat (5) step();
        check("first_valid_cycle", 32'(firstValidCyc), 32'd2);
        check("stall_req_count", 32'(fireCnt), 32'(DEPTH));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(instr_valid), 32'd1);
        check("stall_instr_pc", instr_pc, 32'h0);
        check("stall_instr_pcplus4", instr_pcplus4, 32'h4);

        // Release decode: in-order stream 0x0, 0x4, 0x8 ... with no loss
        instr_ready = 1'b1;
        popCnt      = 0;
        repeat (14) step();
        check("stream_delivered", 32'(popCnt >= 5), 32'd1);

        // Empty queue presents NOP to decode
        drain("drain_before_empty");
        check("empty_instr_valid", 32'(instr_valid), 32'd0);
        check("empty_instr", instr, NOP_INSTR);
        check("empty_instr_op", {25'd0, instr_op}, {25'd0, OP_ITYPE});
        check("empty_req_valid", 32'(imem_req_valid), 32'd1);

        // 3-cycle memory, redirect with two requests in flight
        lat            = 3;
        imem_req_ready = 1'b1;
        fireCnt        = 0;
        step();
        step();
        check("inflight_count", 32'(fireCnt), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        check("redir_no_req", 32'(lastReqValid), 32'd0);
        redirect    = 1'b0;
        redirect_pc = '0;
        runPops(3, "redir100_pops");

        // Redirect in the same cycle as a response, unaligned target
        drain("drain_before_redir2");
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        check("redir2_no_req", 32'(lastReqValid), 32'd0);
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        runPops(3, "redir200_pops");

        // Asynchronous reset mid-stream with both entries filled
        drain("drain_before_reset");
        lat            = 1;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        repeat (4) step();
        check("prereset_instr_valid", 32'(instr_valid), 32'd1);
        check("prereset_req_valid", 32'(imem_req_valid), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_instr_valid", 32'(instr_valid), 32'd0);
        check("midreset_req_valid", 32'(imem_req_valid), 32'd0);
        check("midreset_instr", instr, NOP_INSTR);
        expQ.delete();
        pendQ.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        nextAddr       = RESET_PC;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        instr_ready = 1'b1;
        runPops(3, "postreset_pops");

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
